// File: rtl/lpm_pkg.sv
// Shared constants and helpers for the LPM megafunction simulation models.
// Holds the direction encoding and modulus computation used by lpm_modcounter.
package lpm_pkg;

  localparam int LPM_MAX_WIDTH = 32;

  typedef enum logic {
    LPM_DIR_DOWN = 1'b0,
    LPM_DIR_UP   = 1'b1
  } lpm_dir_e;

  // Modulus 0 means the full 2^width range; result needs width+1 bits.
  function automatic logic [LPM_MAX_WIDTH:0] lpm_mod_value(
    input int width,
    input int modulus
  );
    logic [LPM_MAX_WIDTH:0] m;
    if (modulus == 0)
      m = (LPM_MAX_WIDTH+1)'(1) << width;
    else
      m = (LPM_MAX_WIDTH+1)'(modulus);
    return m;
  endfunction

endpackage

// File: rtl/lpm_modcounter_next.sv
// Combinational next-count logic for lpm_modcounter.
// Produces the next count plus wrap and out-of-range-load flags.
module lpm_modcounter_next
  import lpm_pkg::*;
#(
  parameter int           W  = 8,
  parameter logic [W:0]   MV = '0
) (
  input  logic [W-1:0] i_q,
  input  logic [W-1:0] i_data,
  input  logic         i_sload,
  input  logic         i_cnt_en,
  input  logic         i_up,
  output logic [W-1:0] o_nxt_q,
  output logic         o_wrap,
  output logic         o_range_err
);

  logic [W:0]   w_inc;
  logic [W-1:0] w_dec;
  logic [W-1:0] w_top;

  // Increment kept one bit wider so M = 2^W compares without aliasing.
  assign w_inc = {1'b0, i_q} + (W+1)'(1);
  assign w_dec = i_q - W'(1);
  assign w_top = W'(MV - (W+1)'(1));

  always_comb begin
    o_nxt_q     = i_q;
    o_wrap      = 1'b0;
    o_range_err = 1'b0;
    unique case (1'b1)
      i_sload: begin
        if ({1'b0, i_data} >= MV) begin
          o_nxt_q     = '0;
          o_range_err = 1'b1;
        end else begin
          o_nxt_q = i_data;
        end
      end
      (!i_sload && i_cnt_en && i_up): begin
        if (w_inc == MV) begin
          o_nxt_q = '0;
          o_wrap  = 1'b1;
        end else begin
          o_nxt_q = w_inc[W-1:0];
        end
      end
      (!i_sload && i_cnt_en && !i_up): begin
        if (i_q == '0) begin
          o_nxt_q = w_top;
          o_wrap  = 1'b1;
        end else begin
          o_nxt_q = w_dec;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lpm_modcounter.sv
// Modulus counter with synchronous load, terminal-count and load-range pulses.
// Define LPM_MODCOUNTER_UPDOWN_EN to add the updown port for runtime direction.
module lpm_modcounter
  import lpm_pkg::*;
#(
  parameter int    lpm_width     = 8,
  parameter int    lpm_modulus   = 0,
  parameter string lpm_direction = "UP",
  parameter string lpm_type      = "lpm_modcounter"
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cnt_en,
  input  logic                 sload,
`ifdef LPM_MODCOUNTER_UPDOWN_EN
  input  logic                 updown,
`endif
  input  logic [lpm_width-1:0] data,
  output logic [lpm_width-1:0] q,
  output logic                 cout,
  output logic                 load_err
);

  localparam logic [LPM_MAX_WIDTH:0] M_FULL =
    lpm_mod_value(lpm_width, lpm_modulus);
  localparam logic [lpm_width:0] MV = M_FULL[lpm_width:0];

  if (lpm_width < 1 || lpm_width > LPM_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "lpm_modcounter: lpm_width out of range 1..32");
  end

  if (lpm_modulus < 0 ||
      64'(lpm_modulus) > (64'd1 << lpm_width)) begin : g_bad_mod
    $fatal(1, "lpm_modcounter: lpm_modulus exceeds 2^lpm_width");
  end

  if (lpm_direction != "UP" &&
      lpm_direction != "DOWN") begin : g_bad_dir
    $fatal(1, "lpm_modcounter: lpm_direction must be UP or DOWN");
  end

  logic                 w_up;
  logic [lpm_width-1:0] w_nxt_q;
  logic                 w_wrap;
  logic                 w_range_err;

`ifdef LPM_MODCOUNTER_UPDOWN_EN
  assign w_up = updown;
`else
  localparam lpm_dir_e DIR =
    (lpm_direction == "DOWN") ? LPM_DIR_DOWN : LPM_DIR_UP;
  assign w_up = (DIR == LPM_DIR_UP);
`endif

  lpm_modcounter_next #(
    .W  (lpm_width),
    .MV (MV)
  ) u_next (
    .i_q         (q),
    .i_data      (data),
    .i_sload     (sload),
    .i_cnt_en    (cnt_en),
    .i_up        (w_up),
    .o_nxt_q     (w_nxt_q),
    .o_wrap      (w_wrap),
    .o_range_err (w_range_err)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q        <= '0;
      cout     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= w_nxt_q;
      cout     <= w_wrap;
      load_err <= w_range_err;
    end
  end

endmodule

// File: tb/tb_lpm_modcounter.sv
// Self-checking bench for lpm_modcounter: three configurations against a
// modular-arithmetic model, plus hand-computed directed expectations.
module tb_lpm_modcounter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cnt_en = 1'b0;
  logic       sload = 1'b0;
  logic [3:0] data4 = '0;
  logic [2:0] data3 = '0;
  logic       ud = 1'b1;

  logic [3:0] q_up, q_dn;
  logic [2:0] q_fr;
  logic       c_up, c_dn, c_fr;
  logic       e_up, e_dn, e_fr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lpm_modcounter #(.lpm_width(4), .lpm_modulus(10),
                   .lpm_direction("UP")) u_up (
    .clock(clk), .reset_n(rst_n), .cnt_en(cnt_en), .sload(sload),
`ifdef LPM_MODCOUNTER_UPDOWN_EN
    .updown(ud),
`endif
    .data(data4), .q(q_up), .cout(c_up), .load_err(e_up));

  lpm_modcounter #(.lpm_width(4), .lpm_modulus(10),
                   .lpm_direction("DOWN")) u_dn (
    .clock(clk), .reset_n(rst_n), .cnt_en(cnt_en), .sload(sload),
`ifdef LPM_MODCOUNTER_UPDOWN_EN
    .updown(1'b0),
`endif
    .data(data4), .q(q_dn), .cout(c_dn), .load_err(e_dn));

  lpm_modcounter #(.lpm_width(3), .lpm_modulus(0),
                   .lpm_direction("UP")) u_fr (
    .clock(clk), .reset_n(rst_n), .cnt_en(cnt_en), .sload(sload),
`ifdef LPM_MODCOUNTER_UPDOWN_EN
    .updown(1'b1),
`endif
    .data(data3), .q(q_fr), .cout(c_fr), .load_err(e_fr));

  task automatic chk(input string nm, input logic [32:0] act,
                     input logic [32:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: count lives in Z_M; wrap is when the count passes through M-1 -> 0.
  int mq[3];
  int mc[3];
  int me[3];
  int mm[3] = '{10, 10, 8};

  function automatic bit model_up(int i);
    if (i == 1) return 1'b0;
`ifdef LPM_MODCOUNTER_UPDOWN_EN
    if (i == 0) return ud;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mq[i] = 0; mc[i] = 0; me[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int d;
        d = (i == 2) ? int'(data3) : int'(data4);
        if (sload) begin
          mc[i] = 0;
          me[i] = (d >= mm[i]) ? 1 : 0;
          mq[i] = (d >= mm[i]) ? 0 : d;
        end else if (cnt_en) begin
          me[i] = 0;
          if (model_up(i)) begin
            mq[i] = (mq[i] + 1) % mm[i];
            mc[i] = (mq[i] == 0) ? 1 : 0;
          end else begin
            mc[i] = (mq[i] == 0) ? 1 : 0;
            mq[i] = (mq[i] + mm[i] - 1) % mm[i];
          end
        end else begin
          mc[i] = 0;
          me[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_q_up", q_up, mq[0]);
    chk("m_c_up", c_up, mc[0]);
    chk("m_e_up", e_up, me[0]);
    chk("m_q_dn", q_dn, mq[1]);
    chk("m_c_dn", c_dn, mc[1]);
    chk("m_e_dn", e_dn, me[1]);
    chk("m_q_fr", q_fr, mq[2]);
    chk("m_c_fr", c_fr, mc[2]);
    chk("m_e_fr", e_fr, me[2]);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_dn[3]  = '{0, 9, 8};

  typedef struct {
    logic       sl;
    logic       en;
    logic [3:0] d4;
    logic [2:0] d3;
  } vec_t;

  vec_t tbl[10] = '{
    '{1'b1, 1'b0, 4'd9, 3'd6},
    '{1'b0, 1'b1, 4'd0, 3'd0},
    '{1'b0, 1'b0, 4'd0, 3'd0},
    '{1'b1, 1'b1, 4'd15, 3'd2},
    '{1'b0, 1'b1, 4'd0, 3'd0},
    '{1'b0, 1'b1, 4'd0, 3'd0},
    '{1'b1, 1'b0, 4'd10, 3'd7},
    '{1'b0, 1'b1, 4'd3, 3'd1},
    '{1'b1, 1'b1, 4'd0, 3'd0},
    '{1'b0, 1'b1, 4'd0, 3'd0}
  };

  initial begin
    #2;
    chk("rst_q", q_up, 0);
    chk("rst_cout", c_up, 0);
    chk("rst_err", e_up, 0);
    @(negedge clk);
    rst_n = 1'b1;

    sload = 1'b1; data4 = 4'd0; data3 = 3'd0;
    step();
    sload = 1'b0; cnt_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("upwrap_q", q_up, exp_up[i]);
      chk("upwrap_cout", c_up, (i == 9) ? 1 : 0);
    end

    cnt_en = 1'b0; sload = 1'b1; data4 = 4'd4; data3 = 3'd4;
    step();
    sload = 1'b0; cnt_en = 1'b1;
    step();
    chk("pre_rst_q", q_up, 5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_q", q_up, 0);
    chk("async_rst_cout", c_up, 0);
    chk("async_rst_err", e_up, 0);
    chk("async_rst_qdn", q_dn, 0);
    @(negedge clk);
    rst_n = 1'b1; cnt_en = 1'b0;

    sload = 1'b1; data4 = 4'd1;
    step();
    sload = 1'b0; cnt_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dnwrap_q", q_dn, exp_dn[i]);
      chk("dnwrap_cout", c_dn, (i == 1) ? 1 : 0);
    end

    cnt_en = 1'b0; sload = 1'b1; data4 = 4'd7;
    step();
    chk("load7_q", q_up, 7);
    chk("load7_err", e_up, 0);
    data4 = 4'd12;
    step();
    chk("load12_q", q_up, 0);
    chk("load12_err", e_up, 1);
    sload = 1'b0;
    step();
    chk("err_pulse_end", e_up, 0);

    sload = 1'b1; data3 = 3'd7;
    step();
    chk("fr_load7", q_fr, 7);
    sload = 1'b0; cnt_en = 1'b1;
    step();
    chk("fr_wrap_q", q_fr, 0);
    chk("fr_wrap_cout", c_fr, 1);
    sload = 1'b1; data3 = 3'd3;
    step();
    chk("prio_q", q_fr, 3);
    chk("prio_cout", c_fr, 0);

`ifdef LPM_MODCOUNTER_UPDOWN_EN
    cnt_en = 1'b0; sload = 1'b1; data4 = 4'd2;
    step();
    sload = 1'b0; cnt_en = 1'b1;
    ud = 1'b1; step(); chk("ud_q1", q_up, 3);
    ud = 1'b1; step(); chk("ud_q2", q_up, 4);
    ud = 1'b0; step(); chk("ud_q3", q_up, 3);
    ud = 1'b1;
`endif

    for (int i = 0; i < 10; i++) begin
      sload = tbl[i].sl; cnt_en = tbl[i].en;
      data4 = tbl[i].d4; data3 = tbl[i].d3;
      step();
    end
    sload = 1'b0; cnt_en = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
